// File: rtl/i2c_write_master.sv
// i2c_write_master: single-master I2C write engine.
// Each accepted start issues START, {address,W}, data_0, data_1, STOP on an
// open-drain bus driven through scl_oe/sda_oe (1 = pull low, 0 = release).
// A NACK in any ACK slot sets the sticky ack_error and jumps straight to STOP.

module i2c_write_master #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] address,
    input  logic [7:0] data_0,
    input  logic [7:0] data_1,
    output logic       busy,
    output logic       ack_error,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_BYTE,
        ST_STOP
    } state_t;

    state_t      state;
    logic [15:0] div_cnt;
    logic [1:0]  quarter;
    logic [3:0]  bit_idx;
    logic [1:0]  byte_idx;
    logic [23:0] shift;
    logic        tick;

    // Quarter-period tick fires on the last count of the divider.
    assign tick = (div_cnt == DIV_LAST);

    // Bus sequencer: every output is registered and set for the quarter being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            quarter   <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            shift     <= '0;
            busy      <= 1'b0;
            ack_error <= 1'b0;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shift     <= {address, 1'b0, data_0, data_1};
                        ack_error <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_START;
                        div_cnt   <= '0;
                        quarter   <= '0;
                        bit_idx   <= '0;
                        byte_idx  <= '0;
                        scl_oe    <= 1'b0;
                        sda_oe    <= 1'b0;
                    end
                end
                default: begin
                    if (!tick) begin
                        div_cnt <= div_cnt + 16'd1;
                    end else begin
                        div_cnt <= '0;
                        quarter <= quarter + 2'd1;
                        case (state)
                            ST_START: begin
                                case (quarter)
                                    2'd0: sda_oe <= 1'b1;
                                    2'd3: begin
                                        state   <= ST_BYTE;
                                        bit_idx <= '0;
                                        scl_oe  <= 1'b1;
                                        sda_oe  <= ~shift[23];
                                        shift   <= {shift[22:0], 1'b0};
                                    end
                                    default: ;
                                endcase
                            end
                            ST_BYTE: begin
                                case (quarter)
                                    2'd1: scl_oe <= 1'b0;
                                    2'd2: begin
                                        if (bit_idx == 4'd8 && sda_in) begin
                                            ack_error <= 1'b1;
                                        end
                                    end
                                    2'd3: begin
                                        scl_oe <= 1'b1;
                                        if (bit_idx == 4'd8) begin
                                            if (ack_error || byte_idx == 2'd2) begin
                                                state  <= ST_STOP;
                                                sda_oe <= 1'b1;
                                            end else begin
                                                byte_idx <= byte_idx + 2'd1;
                                                bit_idx  <= '0;
                                                sda_oe   <= ~shift[23];
                                                shift    <= {shift[22:0], 1'b0};
                                            end
                                        end else if (bit_idx == 4'd7) begin
                                            bit_idx <= 4'd8;
                                            sda_oe  <= 1'b0;
                                        end else begin
                                            bit_idx <= bit_idx + 4'd1;
                                            sda_oe  <= ~shift[23];
                                            shift   <= {shift[22:0], 1'b0};
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                            ST_STOP: begin
                                case (quarter)
                                    2'd0: scl_oe <= 1'b0;
                                    2'd1: sda_oe <= 1'b0;
                                    2'd3: begin
                                        state <= ST_IDLE;
                                        busy  <= 1'b0;
                                    end
                                    default: ;
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_write_master.sv
// tb_i2c_write_master: directed bench with an ACKing/NACKing slave model,
// a byte scoreboard and a bus-rule monitor counting START/STOP conditions.

module tb_i2c_write_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] address;
    logic [7:0] data_0;
    logic [7:0] data_1;
    logic       busy;
    logic       ack_error;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_in;
    logic       slave_pull = 1'b0;

    logic [2:0] nack_mask;
    logic [7:0] exp_q[$];
    logic [7:0] rx_log[$];
    int         rd_idx = 0;
    int         errors = 0;
    int         checks = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;

    logic       scl_q = 1'b1;
    logic       sda_q = 1'b1;
    int         bits = 0;
    logic [1:0] byte_no = 2'd0;
    logic [7:0] shreg = 8'd0;

    i2c_write_master #(.CLK_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .address   (address),
        .data_0    (data_0),
        .data_1    (data_1),
        .busy      (busy),
        .ack_error (ack_error),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .sda_in    (sda_in)
    );

    // Wired-AND SDA line seen by both master and slave.
    assign sda_in = ~(sda_oe | slave_pull);

    // Clock generation.
    always #5 clk = ~clk;

    // Slave model and bus monitor, sampled on the falling system clock.
    always @(negedge clk) begin
        if (rst) begin
            bits       <= 0;
            slave_pull <= 1'b0;
            byte_no    <= 2'd0;
        end else begin
            if (scl_q && !scl_oe && sda_q && !sda_in) begin
                start_cnt <= start_cnt + 1;
                bits      <= 0;
                byte_no   <= 2'd0;
            end else if (scl_q && !scl_oe && !sda_q && sda_in) begin
                stop_cnt   <= stop_cnt + 1;
                bits       <= 0;
                slave_pull <= 1'b0;
            end else if (!scl_q && !scl_oe) begin
                if (bits < 8) begin
                    shreg <= {shreg[6:0], sda_in};
                    bits  <= bits + 1;
                end
            end else if (scl_q && scl_oe) begin
                if (bits == 8) begin
                    rx_log.push_back(shreg);
                    slave_pull <= (byte_no == 2'd3) ? 1'b0 : ~nack_mask[byte_no];
                    bits       <= 9;
                end else if (bits == 9) begin
                    slave_pull <= 1'b0;
                    bits       <= 0;
                    byte_no    <= byte_no + 2'd1;
                end
            end
        end
        scl_q <= ~scl_oe;
        sda_q <= sda_in;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] a, input logic [7:0] d0,
                                 input logic [7:0] d1, input logic [2:0] mask);
        address   = a;
        data_0    = d0;
        data_1    = d1;
        nack_mask = mask;
        exp_q.push_back({a, 1'b0});
        if (!mask[0]) exp_q.push_back(d0);
        if (!mask[0] && !mask[1]) exp_q.push_back(d1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 3000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic checkBytes();
        logic [7:0] exp_b;
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            if (rd_idx < rx_log.size()) begin
                checkOutput("bus_byte", 32'(rx_log[rd_idx]), 32'(exp_b));
                rd_idx++;
            end else begin
                checkOutput("bus_byte_count", 32'(rx_log.size()), 32'(rd_idx + 1));
            end
        end
        checkOutput("extra_bus_bytes", 32'(rx_log.size() - rd_idx), 32'd0);
        rd_idx = rx_log.size();
    endtask

    initial begin
        int cyc;
        int s0;
        int p0;
        rst       = 1'b1;
        start     = 1'b0;
        address   = '0;
        data_0    = '0;
        data_1    = '0;
        nack_mask = 3'b000;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_ack_error", 32'(ack_error), 32'd0);
        checkOutput("reset_scl_oe", 32'(scl_oe), 32'd0);
        checkOutput("reset_sda_oe", 32'(sda_oe), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] clean transfer 0x39 / 0x41 / 0x10");
        s0 = start_cnt;
        p0 = stop_cnt;
        applyStimulus(7'h39, 8'h41, 8'h10, 3'b000);
        checkOutput("accept_busy", 32'(busy), 32'd1);
        waitDone(cyc);
        checkOutput("busy_cycles_clean", 32'(cyc), 32'd464);
        checkOutput("ack_error_clean", 32'(ack_error), 32'd0);
        checkBytes();
        checkOutput("start_conditions", 32'(start_cnt - s0), 32'd1);
        checkOutput("stop_conditions", 32'(stop_cnt - p0), 32'd1);

        $display("[TB] address NACK");
        @(negedge clk);
        applyStimulus(7'h39, 8'h41, 8'h10, 3'b001);
        waitDone(cyc);
        checkOutput("busy_cycles_addr_nack", 32'(cyc), 32'd176);
        checkOutput("ack_error_addr_nack", 32'(ack_error), 32'd1);
        checkBytes();

        $display("[TB] data_1 NACK then clean transfer");
        @(negedge clk);
        applyStimulus(7'h39, 8'h41, 8'h10, 3'b100);
        waitDone(cyc);
        checkOutput("busy_cycles_d1_nack", 32'(cyc), 32'd464);
        checkOutput("ack_error_d1_nack", 32'(ack_error), 32'd1);
        checkBytes();
        @(negedge clk);
        applyStimulus(7'h50, 8'hA5, 8'h3C, 3'b000);
        checkOutput("ack_error_clear_on_accept", 32'(ack_error), 32'd0);
        waitDone(cyc);
        checkOutput("busy_cycles_after_nack", 32'(cyc), 32'd464);
        checkBytes();

        $display("[TB] start held high and inputs changed mid-transfer");
        s0 = start_cnt;
        @(negedge clk);
        applyStimulus(7'h2A, 8'hC3, 8'h5E, 3'b000);
        start = 1'b1;
        repeat (40) @(negedge clk);
        address = 7'h11;
        data_0  = 8'hFF;
        data_1  = 8'h00;
        waitDone(cyc);
        start = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("no_second_transaction", 32'(busy), 32'd0);
        checkOutput("single_start_condition", 32'(start_cnt - s0), 32'd1);
        checkBytes();

        $display("[TB] reset in bit slot 10");
        @(negedge clk);
        applyStimulus(7'h39, 8'h41, 8'h10, 3'b000);
        repeat (176) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_scl_oe", 32'(scl_oe), 32'd0);
        checkOutput("async_rst_sda_oe", 32'(sda_oe), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        rd_idx = rx_log.size();
        repeat (2) @(negedge clk);
        applyStimulus(7'h39, 8'h41, 8'h10, 3'b000);
        waitDone(cyc);
        checkOutput("busy_cycles_after_rst", 32'(cyc), 32'd464);
        checkOutput("ack_error_after_rst", 32'(ack_error), 32'd0);
        checkBytes();

        $display("[TB] 25 back-to-back transfers");
        s0 = start_cnt;
        p0 = stop_cnt;
        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            applyStimulus(7'($urandom), 8'($urandom), 8'($urandom), 3'b000);
            checkOutput("b2b_accept", 32'(busy), 32'd1);
            waitDone(cyc);
            checkOutput("b2b_busy_cycles", 32'(cyc), 32'd464);
            checkBytes();
        end
        checkOutput("b2b_start_conditions", 32'(start_cnt - s0), 32'd25);
        checkOutput("b2b_stop_conditions", 32'(stop_cnt - p0), 32'd25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
